// File: rtl/pll_dyn_ctrl.sv
// Reset, lock-wait and retry sequencer for a PLL with a dynamic loop-filter port.
// Runs on the PLL reference clock. The lock input is synchronized before the FSM uses it.
module pll_dyn_ctrl #(
  parameter logic [5:0] ICPSEL_INIT   = 6'd16,
  parameter logic [2:0] LPFRES_INIT   = 3'd2,
  parameter logic [1:0] LPFCAP_INIT   = 2'd0,
  parameter int         RESET_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT  = 500000,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         MAX_RETRIES   = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               lock,
  output logic                               pll_reset,
  output logic [5:0]                         icpsel,
  output logic [2:0]                         lpfres,
  output logic [1:0]                         lpfcap,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [5:0]                         cfg_icpsel,
  input  logic [2:0]                         cfg_lpfres,
  input  logic [1:0]                         cfg_lpfcap,
  output logic                               ready,
  output logic                               fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(STABLE_CYCLES + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_TGT = SW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {ST_RST, ST_WAIT, ST_RUN, ST_FAIL} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_stab, w_stab_nxt, w_stab_inc;
  logic [RW-1:0]   r_retry, w_retry_nxt, w_retry_inc;
  logic            r_lock_meta, r_lock_s;
  logic            r_pll_reset, r_ready, r_fail, r_lock_lost;
  logic [5:0]      r_icpsel;
  logic [2:0]      r_lpfres;
  logic [1:0]      r_lpfcap;
  logic            w_cfg_acc, w_lost;

  assign pll_reset = r_pll_reset;
  assign icpsel    = r_icpsel;
  assign lpfres    = r_lpfres;
  assign lpfcap    = r_lpfcap;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;

  // Requests made while a lock attempt is in flight simply stall.
  assign cfg_ready = cfg_valid && ((r_state == ST_RUN) || (r_state == ST_FAIL));

  assign w_stab_inc  = r_lock_s ? (r_stab + 1'b1) : '0;
  assign w_retry_inc = r_retry + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stab_nxt  = '0;
    w_retry_nxt = r_retry;
    w_cfg_acc   = 1'b0;
    w_lost      = 1'b0;
    case (r_state)
      ST_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        w_stab_nxt = w_stab_inc;
        w_cnt_nxt  = r_cnt + 1'b1;
        // A stable lock on the final timeout cycle still counts as success.
        if (w_stab_inc == STAB_TGT) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_nxt   = '0;
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RETRY_MX) ? ST_FAIL : ST_RST;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_lost      = 1'b1;
          w_state_nxt = ST_RST;
          w_cnt_nxt   = '0;
        end
        if (cfg_valid) begin
          w_cfg_acc   = 1'b1;
          w_state_nxt = ST_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      ST_FAIL: begin
        if (cfg_valid) begin
          w_cfg_acc   = 1'b1;
          w_state_nxt = ST_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= ST_RST;
      r_cnt       <= '0;
      r_stab      <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_icpsel    <= ICPSEL_INIT;
      r_lpfres    <= LPFRES_INIT;
      r_lpfcap    <= LPFCAP_INIT;
    end else begin
      r_lock_meta <= lock;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stab      <= w_stab_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_FAIL);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
      r_lock_lost <= w_lost;
      // Settings only move on the edge into RST, so they are frozen while pll_reset is low.
      if (w_cfg_acc) begin
        r_icpsel <= cfg_icpsel;
        r_lpfres <= cfg_lpfres;
        r_lpfcap <= cfg_lpfcap;
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl with short timing parameters.
// Each step lands 1 time unit after a rising edge, where inputs are driven and outputs checked.
module tb_pll_dyn_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lock;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_icpsel;
  logic [2:0] cfg_lpfres;
  logic [1:0] cfg_lpfcap;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  pll_dyn_ctrl #(
    .ICPSEL_INIT(6'd16), .LPFRES_INIT(3'd2), .LPFCAP_INIT(2'd0),
    .RESET_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lock(lock), .pll_reset(pll_reset),
    .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_icpsel(cfg_icpsel), .cfg_lpfres(cfg_lpfres), .cfg_lpfcap(cfg_lpfcap),
    .ready(ready), .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic saw_ready;

  initial begin
    reset_n    = 1'b0;
    lock       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_icpsel = 6'd0;
    cfg_lpfres = 3'd0;
    cfg_lpfcap = 2'd0;
    step(2);
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_icpsel", 32'(icpsel), 16);
    chk("rst_lpfres", 32'(lpfres), 2);
    chk("rst_lpfcap", 32'(lpfcap), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);

    // Nominal lock: pll_reset held 4 edges, lock comes 10 cycles later, ready 20 edges after the fall.
    reset_n = 1'b1;
    step(3);
    chk("nom_prst_held", 32'(pll_reset), 1);
    step(1);
    chk("nom_prst_fall", 32'(pll_reset), 0);
    step(10);
    lock = 1'b1;
    step(9);
    chk("nom_ready_early", 32'(ready), 0);
    step(1);
    chk("nom_ready", 32'(ready), 1);
    chk("nom_icpsel", 32'(icpsel), 16);
    chk("nom_retry", 32'(retry_cnt), 0);

    // Lock loss in RUN: one-cycle dropout.
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(1);
    chk("loss_ready_pre", 32'(ready), 1);
    step(1);
    chk("loss_pulse", 32'(lock_lost), 1);
    chk("loss_ready_fall", 32'(ready), 0);
    chk("loss_prst", 32'(pll_reset), 1);
    step(1);
    chk("loss_pulse_end", 32'(lock_lost), 0);
    step(2);
    chk("loss_prst_held", 32'(pll_reset), 1);
    step(1);
    chk("loss_prst_fall", 32'(pll_reset), 0);
    step(7);
    chk("loss_ready_early", 32'(ready), 0);
    step(1);
    chk("loss_relock", 32'(ready), 1);
    chk("loss_retry", 32'(retry_cnt), 0);

    // Config accepted in RUN, then a request held in RST must stall.
    cfg_valid  = 1'b1;
    cfg_icpsel = 6'd20;
    cfg_lpfres = 3'd3;
    cfg_lpfcap = 2'd2;
    #0;
    chk("cfg_run_ready", 32'(cfg_ready), 1);
    step(1);
    chk("cfg_run_icpsel", 32'(icpsel), 20);
    chk("cfg_run_lpfres", 32'(lpfres), 3);
    chk("cfg_run_lpfcap", 32'(lpfcap), 2);
    chk("cfg_run_prst", 32'(pll_reset), 1);
    chk("cfg_rst_stall", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    lock      = 1'b0;
    step(4);
    chk("glitch_prst_fall", 32'(pll_reset), 0);

    // Glitchy lock: 5 high / 5 low twice, never 8 consecutive; then steady.
    saw_ready = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      lock = (ph % 2 == 0);
      for (int k = 0; k < 5; k++) begin
        step(1);
        saw_ready = saw_ready | ready;
      end
    end
    chk("glitch_no_ready", 32'(saw_ready), 0);
    lock = 1'b1;
    step(9);
    chk("glitch_ready_early", 32'(ready), 0);
    step(1);
    chk("glitch_ready", 32'(ready), 1);
    chk("glitch_retry", 32'(retry_cnt), 0);

    // Timeout to FAIL: three 64-cycle windows separated by 4-cycle resets.
    lock = 1'b0;
    step(3);
    chk("tmo_lock_lost", 32'(lock_lost), 1);
    step(4);
    chk("tmo_w1_start", 32'(pll_reset), 0);
    step(63);
    chk("tmo_w1_end_prst", 32'(pll_reset), 0);
    chk("tmo_w1_end_retry", 32'(retry_cnt), 0);
    step(1);
    chk("tmo_r1_prst", 32'(pll_reset), 1);
    chk("tmo_r1_retry", 32'(retry_cnt), 1);
    step(3);
    chk("tmo_r1_held", 32'(pll_reset), 1);
    step(1);
    chk("tmo_w2_start", 32'(pll_reset), 0);
    step(63);
    chk("tmo_w2_end_retry", 32'(retry_cnt), 1);
    step(1);
    chk("tmo_r2_retry", 32'(retry_cnt), 2);
    chk("tmo_r2_prst", 32'(pll_reset), 1);
    step(4);
    chk("tmo_w3_start", 32'(pll_reset), 0);
    step(63);
    chk("tmo_w3_end_fail", 32'(fail), 0);
    step(1);
    chk("tmo_fail", 32'(fail), 1);
    chk("tmo_retry3", 32'(retry_cnt), 3);
    chk("tmo_fail_prst", 32'(pll_reset), 1);
    step(20);
    chk("tmo_fail_hold", 32'(fail), 1);
    chk("tmo_prst_hold", 32'(pll_reset), 1);
    chk("tmo_ready_low", 32'(ready), 0);
    chk("tmo_icpsel_kept", 32'(icpsel), 20);

    // Recovery from FAIL with a new configuration.
    cfg_valid  = 1'b1;
    cfg_icpsel = 6'd40;
    cfg_lpfres = 3'd5;
    cfg_lpfcap = 2'd1;
    lock       = 1'b1;
    #0;
    chk("rec_cfg_ready", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    chk("rec_icpsel", 32'(icpsel), 40);
    chk("rec_lpfres", 32'(lpfres), 5);
    chk("rec_lpfcap", 32'(lpfcap), 1);
    chk("rec_fail_clr", 32'(fail), 0);
    chk("rec_retry_clr", 32'(retry_cnt), 0);
    chk("rec_prst", 32'(pll_reset), 1);
    step(4);
    chk("rec_prst_fall", 32'(pll_reset), 0);
    step(7);
    chk("rec_ready_early", 32'(ready), 0);
    step(1);
    chk("rec_ready", 32'(ready), 1);

    // Reset asserted mid-WAIT after another config update.
    cfg_valid  = 1'b1;
    cfg_icpsel = 6'd50;
    cfg_lpfres = 3'd6;
    cfg_lpfcap = 2'd3;
    step(1);
    cfg_valid = 1'b0;
    step(5);
    chk("mid_wait_prst", 32'(pll_reset), 0);
    chk("mid_wait_icpsel", 32'(icpsel), 50);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_prst", 32'(pll_reset), 1);
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_icpsel", 32'(icpsel), 16);
    chk("mid_rst_lpfres", 32'(lpfres), 2);
    chk("mid_rst_lpfcap", 32'(lpfcap), 0);
    chk("mid_rst_retry", 32'(retry_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
